// File: rtl/sfx_arbiter.sv
// Fixed-priority sound-effect arbiter: latches event pulses, times each tone and a silent gap.
// Optional SFX_ARB_PENDING_EN keeps lower-priority/gap requests queued for replay after the gap.
module sfx_arbiter #(
  parameter int         DUR_W   = 27,
  parameter int         DUR0    = 5_000_000,
  parameter int         DUR1    = 10_000_000,
  parameter int         DUR2    = 50_000_000,
  parameter int         DUR3    = 50_000_000,
  parameter logic [2:0] TONE0   = 3'd1,
  parameter logic [2:0] TONE1   = 3'd2,
  parameter logic [2:0] TONE2   = 3'd3,
  parameter logic [2:0] TONE3   = 3'd4,
  parameter int         GAP_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [2:0] sel,
  output logic       en,
  output logic [3:0] grant,
  output logic       busy,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [DUR_W-1:0] GAP_M1 = DUR_W'(GAP_CYC - 1);

  state_t           state, state_n;
  logic [DUR_W-1:0] cnt, cnt_n;
  logic [1:0]       cur, cur_n;
  logic [3:0]       cand;
  logic [3:0]       above;
  logic             do_grant;
  logic [1:0]       gnt_idx;

  function automatic logic [DUR_W-1:0] dur_m1(input logic [1:0] i);
    case (i)
      2'd0:    dur_m1 = DUR_W'(DUR0 - 1);
      2'd1:    dur_m1 = DUR_W'(DUR1 - 1);
      2'd2:    dur_m1 = DUR_W'(DUR2 - 1);
      default: dur_m1 = DUR_W'(DUR3 - 1);
    endcase
  endfunction

  function automatic logic [2:0] tone_of(input logic [1:0] i);
    case (i)
      2'd0:    tone_of = TONE0;
      2'd1:    tone_of = TONE1;
      2'd2:    tone_of = TONE2;
      default: tone_of = TONE3;
    endcase
  endfunction

  function automatic logic [1:0] hi_idx(input logic [3:0] v);
    if (v[3])      hi_idx = 2'd3;
    else if (v[2]) hi_idx = 2'd2;
    else if (v[1]) hi_idx = 2'd1;
    else           hi_idx = 2'd0;
  endfunction

`ifdef SFX_ARB_PENDING_EN
  logic [3:0] pending, pending_n;
  logic [3:0] clr;

  assign cand = pending | req;

  // A preempted or retriggered source is never re-queued, so the playing bit is always cleared.
  always_comb begin
    clr = 4'b0000;
    if (do_grant)         clr = clr | (4'b0001 << gnt_idx);
    if (state == S_PLAY)  clr = clr | (4'b0001 << cur);
    pending_n = (pending | req) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= 4'b0000;
    else     pending <= pending_n;
  end
`else
  assign cand = req;
`endif

  assign above = cand & (4'b1110 << cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cur   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur   <= cur_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_n    = cur;
    do_grant = 1'b0;
    gnt_idx  = hi_idx(cand);
    case (state)
      S_IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      S_PLAY: begin
        // Priority inside a tone: preempt, then retrigger, then natural end.
        if (|above) begin
          do_grant = 1'b1;
          gnt_idx  = hi_idx(above);
        end else if (req[cur]) begin
          cnt_n = dur_m1(cur);
        end else if (cnt == '0) begin
          state_n = S_GAP;
          cnt_n   = GAP_M1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
`ifdef SFX_ARB_PENDING_EN
          if (|cand) do_grant = 1'b1;
          else       state_n  = S_IDLE;
`else
          state_n = S_IDLE;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (do_grant) begin
      state_n = S_PLAY;
      cur_n   = gnt_idx;
      cnt_n   = dur_m1(gnt_idx);
    end
  end

  assign sel       = (state == S_PLAY) ? tone_of(cur) : 3'd0;
  assign en        = (state == S_PLAY) && !mute;
  assign grant     = (state == S_PLAY) ? (4'b0001 << cur) : 4'b0000;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule
